// File: rtl/wb_regfile.sv
// Write-back stage: load alignment, write-back select, 2R1W integer register file, instret.
// Define WB_BYPASS_EN for write-first reads of the register being committed this cycle.
module wb_regfile #(
  parameter int REG_NUM = 32,
  parameter int CNT_W   = 64,
  localparam int IDX_W  = $clog2(REG_NUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             W_valid,
  input  logic             W_wb_en,
  input  logic             W_wb_sel,
  input  logic [2:0]       W_funct3,
  input  logic [IDX_W-1:0] W_rd,
  input  logic [31:0]      W_alu_out,
  input  logic [31:0]      W_ld_data,
  input  logic [IDX_W-1:0] D_rs1_index,
  input  logic [IDX_W-1:0] D_rs2_index,
  output logic [31:0]      D_rs1_data,
  output logic [31:0]      D_rs2_data,
  output logic [31:0]      W_wb_data,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [31:0]      rf_q [REG_NUM];
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;

  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_aligned;
  logic        wr_en;

  assign off = W_alu_out[1:0];

  always_comb begin
    ld_byte = W_ld_data[7:0];
    unique case (off)
      2'd0: ld_byte = W_ld_data[7:0];
      2'd1: ld_byte = W_ld_data[15:8];
      2'd2: ld_byte = W_ld_data[23:16];
      2'd3: ld_byte = W_ld_data[31:24];
      default: ld_byte = W_ld_data[7:0];
    endcase
  end

  // Halfword offset only looks at off[1]; misaligned halves are not split.
  assign ld_half = off[1] ? W_ld_data[31:16] : W_ld_data[15:0];

  always_comb begin
    ld_aligned = W_ld_data;
    unique case (W_funct3)
      F3_LB:   ld_aligned = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_aligned = {24'h0, ld_byte};
      F3_LH:   ld_aligned = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  ld_aligned = {16'h0, ld_half};
      F3_LW:   ld_aligned = W_ld_data;
      default: ld_aligned = W_ld_data;
    endcase
  end

  assign W_wb_data = W_wb_sel ? ld_aligned : W_alu_out;

  assign wr_en = W_valid & W_wb_en & (W_rd != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wr_en) begin
      rf_q[W_rd] <= W_wb_data;
    end
  end

  always_comb begin
    instret_d = instret_q;
    if (W_valid) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

  function automatic logic [31:0] rd_port(
    input logic [IDX_W-1:0] idx
  );
    logic [31:0] v;
    v = (idx == '0) ? 32'h0 : rf_q[idx];
`ifdef WB_BYPASS_EN
    if (idx != '0 && idx == W_rd && W_valid && W_wb_en) begin
      v = W_wb_data;
    end
`endif
    return v;
  endfunction

  always_comb begin
    D_rs1_data = rd_port(D_rs1_index);
    D_rs2_data = rd_port(D_rs2_index);
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized self-checking bench for wb_regfile against an array/arithmetic reference.
// Build with WB_BYPASS_EN defined to check write-first reads.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        W_valid;
  logic        W_wb_en;
  logic        W_wb_sel;
  logic [2:0]  W_funct3;
  logic [4:0]  W_rd;
  logic [31:0] W_alu_out;
  logic [31:0] W_ld_data;
  logic [4:0]  D_rs1_index;
  logic [4:0]  D_rs2_index;
  logic [31:0] D_rs1_data;
  logic [31:0] D_rs2_data;
  logic [31:0] W_wb_data;
  logic [63:0] instret;
  logic [31:0] s_rs1, s_rs2, s_wb;
  logic [3:0]  instret4;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]     mdl [32];
  longint unsigned cnt;

  wb_regfile dut (
    .clk(clk), .rst(rst), .W_valid(W_valid), .W_wb_en(W_wb_en),
    .W_wb_sel(W_wb_sel), .W_funct3(W_funct3), .W_rd(W_rd),
    .W_alu_out(W_alu_out), .W_ld_data(W_ld_data),
    .D_rs1_index(D_rs1_index), .D_rs2_index(D_rs2_index),
    .D_rs1_data(D_rs1_data), .D_rs2_data(D_rs2_data),
    .W_wb_data(W_wb_data), .instret(instret)
  );

  wb_regfile #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .W_valid(W_valid), .W_wb_en(W_wb_en),
    .W_wb_sel(W_wb_sel), .W_funct3(W_funct3), .W_rd(W_rd),
    .W_alu_out(W_alu_out), .W_ld_data(W_ld_data),
    .D_rs1_index(D_rs1_index), .D_rs2_index(D_rs2_index),
    .D_rs1_data(s_rs1), .D_rs2_data(s_rs2),
    .W_wb_data(s_wb), .instret(instret4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_wb();
    longint unsigned o, b, h;
    longint unsigned ld;
    ld = W_ld_data;
    if (!W_wb_sel) return W_alu_out;
    o = W_alu_out % 4;
    b = (ld / (longint'(1) << (8 * o))) % 256;
    h = (o >= 2) ? ld / 65536 : ld % 65536;
    case (W_funct3)
      3'd0: return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
      3'd4: return 32'(b);
      3'd1: return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
      3'd5: return 32'(h);
      default: return W_ld_data;
    endcase
  endfunction

  function automatic logic [31:0] ref_rd(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (idx == W_rd && W_valid && W_wb_en) return ref_wb();
`endif
    return mdl[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    cnt = 0;
  endtask

  task automatic tick();
    logic [31:0] wb;
    wb = ref_wb();
    @(posedge clk);
    if (!rst) begin
      if (W_valid && W_wb_en && W_rd != 0) mdl[W_rd] = wb;
      if (W_valid) cnt++;
    end
    #1;
  endtask

  task automatic idle();
    W_valid = 0; W_wb_en = 0; W_wb_sel = 0; W_funct3 = 0;
    W_rd = 0; W_alu_out = 0; W_ld_data = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle();
    model_reset();
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    D_rs1_index = 5; D_rs2_index = 31;
    @(negedge clk);
    vectors++;
    if (D_rs1_data !== 32'h0 || D_rs2_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_read x5=%h x31=%h want 0", D_rs1_data, D_rs2_data);
    end
    vectors++;
    if (instret !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_instret got %0d want 0", instret);
    end
    tick();
    W_valid = 1; W_wb_en = 1; W_rd = 3; W_alu_out = 32'hCAFE_0003;
    rst = 1;
    tick();
    rst = 0; idle();
    D_rs1_index = 3;
    tick();
    vectors++;
    if (D_rs1_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_midwrite x3=%h want 0", D_rs1_data);
    end
  endtask

  task automatic test_alu();
    W_valid = 1; W_wb_en = 1; W_wb_sel = 0; W_rd = 7;
    W_alu_out = 32'h1234_5678;
    tick();
    idle();
    D_rs1_index = 7;
    #1;
    vectors++;
    if (D_rs1_data !== 32'h1234_5678 || instret !== 64'd1) begin
      miscompares++;
      $display("FAIL alu_wb x7=%h instret=%0d want 12345678 1",
               D_rs1_data, instret);
    end
    W_valid = 1; W_wb_en = 1; W_rd = 0; W_alu_out = 32'hFFFF_FFFF;
    tick();
    idle();
    D_rs1_index = 0; D_rs2_index = 0;
    #1;
    vectors++;
    if (D_rs1_data !== 32'h0 || D_rs2_data !== 32'h0) begin
      miscompares++;
      $display("FAIL x0_write x0=%h/%h want 0", D_rs1_data, D_rs2_data);
    end
  endtask

  task automatic test_load();
    logic [2:0]  f3 [5]  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [1:0]  of [5]  = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd1};
    logic [31:0] exp [5] = '{32'hFFFF_FF81, 32'h0000_0080,
                             32'hFFFF_80FF, 32'h0000_7F81, 32'h80FF_7F81};
    for (int i = 0; i < 5; i++) begin
      W_valid = 1; W_wb_en = 1; W_wb_sel = 1; W_rd = 9;
      W_funct3 = f3[i]; W_ld_data = 32'h80FF_7F81;
      W_alu_out = {28'h1000_000, 2'b00, of[i]};
      D_rs1_index = 9;
      @(negedge clk);
      vectors++;
      if (W_wb_data !== exp[i]) begin
        miscompares++;
        $display("FAIL load_ext%0d wb=%h want %h", i, W_wb_data, exp[i]);
      end
      tick();
      idle();
      #1;
      vectors++;
      if (D_rs1_data !== exp[i]) begin
        miscompares++;
        $display("FAIL load_commit%0d x9=%h want %h", i, D_rs1_data, exp[i]);
      end
    end
  endtask

  task automatic test_bubble();
    longint unsigned c0;
    W_valid = 1; W_wb_en = 1; W_rd = 4; W_alu_out = 32'h0000_0044;
    tick();
    c0 = cnt;
    W_valid = 0; W_wb_en = 1; W_rd = 4; W_alu_out = 32'hBAD0_0004;
    D_rs1_index = 4;
    tick();
    vectors++;
    if (D_rs1_data !== 32'h44 || instret !== c0) begin
      miscompares++;
      $display("FAIL bubble x4=%h instret=%0d want 44 %0d",
               D_rs1_data, instret, c0);
    end
    W_valid = 1; W_wb_en = 0;
    tick();
    idle();
    #1;
    vectors++;
    if (D_rs1_data !== 32'h44 || instret !== c0 + 1) begin
      miscompares++;
      $display("FAIL no_wb_en x4=%h instret=%0d want 44 %0d",
               D_rs1_data, instret, c0 + 1);
    end
  endtask

  task automatic test_hazard();
    logic [31:0] same;
`ifdef WB_BYPASS_EN
    same = 32'hDEAD_BEEF;
`else
    same = 32'h0000_0011;
`endif
    W_valid = 1; W_wb_en = 1; W_wb_sel = 0; W_rd = 10;
    W_alu_out = 32'h11;
    tick();
    W_alu_out = 32'hDEAD_BEEF;
    D_rs2_index = 10; D_rs1_index = 10;
    @(negedge clk);
    vectors++;
    if (D_rs2_data !== same || D_rs1_data !== same) begin
      miscompares++;
      $display("FAIL hazard_same rs1=%h rs2=%h want %h",
               D_rs1_data, D_rs2_data, same);
    end
    tick();
    idle();
    #1;
    vectors++;
    if (D_rs2_data !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL hazard_after rs2=%h want deadbeef", D_rs2_data);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2, ew;
    for (int n = 0; n < 300; n++) begin
      W_valid = 1'($urandom_range(0, 3) != 0);
      W_wb_en = 1'($urandom_range(0, 3) != 0);
      W_wb_sel = 1'($urandom);
      W_funct3 = 3'($urandom);
      W_rd = 5'($urandom);
      W_alu_out = $urandom;
      W_ld_data = $urandom;
      D_rs1_index = ($urandom_range(0, 2) == 0) ? W_rd : 5'($urandom);
      D_rs2_index = ($urandom_range(0, 3) == 0) ? D_rs1_index : 5'($urandom);
      @(negedge clk);
      e1 = ref_rd(D_rs1_index);
      e2 = ref_rd(D_rs2_index);
      ew = ref_wb();
      vectors++;
      if (D_rs1_data !== e1 || D_rs2_data !== e2 || W_wb_data !== ew) begin
        miscompares++;
        $display("FAIL rand%0d rs1=%h/%h rs2=%h/%h wb=%h/%h", n,
                 D_rs1_data, e1, D_rs2_data, e2, W_wb_data, ew);
      end
      tick();
      vectors++;
      if (instret !== cnt || instret4 !== 4'(cnt % 16)) begin
        miscompares++;
        $display("FAIL rand_cnt%0d instret=%0d/%0d want %0d/%0d", n,
                 instret, instret4, cnt, cnt % 16);
      end
    end
    idle();
  endtask

  task automatic test_wrap();
    do_reset();
    W_valid = 1; W_wb_en = 0;
    for (int i = 0; i < 17; i++) tick();
    idle();
    #1;
    vectors++;
    if (instret4 !== 4'd1 || instret !== 64'd17) begin
      miscompares++;
      $display("FAIL cnt_wrap instret4=%0d instret=%0d want 1 17",
               instret4, instret);
    end
  endtask

  initial begin
    rst = 1;
    D_rs1_index = 0; D_rs2_index = 0;
    idle();
    test_reset();
    test_alu();
    test_load();
    test_bubble();
    test_hazard();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the M->W pipeline boundary. Consumes the W-stage ALU result and raw load word.
- Aligns and sign/zero-extends load data, then selects the write-back value.
- Commits the write-back value into the architectural integer register file, which has two read ports serving decode.
- Keeps a retired-instruction counter.
- Sits between the W pipeline register and the decode/hazard logic.

Parameters:
- REG_NUM, 32, number of architectural registers; index width is log2(REG_NUM).
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- W_valid  in  1  a real (non-bubble) instruction occupies W this cycle.
- W_wb_en  in  1  instruction writes rd.
- W_wb_sel  in  1  0 = ALU result, 1 = load data.
- W_funct3  in  3  load width/sign code.
- W_rd  in  5  destination register index.
- W_alu_out  in  32  ALU result; for loads, the effective address.
- W_ld_data  in  32  raw aligned memory word.
- D_rs1_index  in  5  read port 1 index.
- D_rs2_index  in  5  read port 2 index.
- D_rs1_data  out  32  read port 1 data, combinational.
- D_rs2_data  out  32  read port 2 data, combinational.
- W_wb_data  out  32  selected write-back value, combinational.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: asserting rst asynchronously clears all registers x0..x(REG_NUM-1) and instret to 0. Reset asserted mid-operation discards any write in that cycle. The first write is accepted on the first rising edge after rst deasserts.
- Load alignment: the byte offset is off = W_alu_out[1:0].
  - funct3 000 (LB): the byte at bit position 8*off, sign-extended.
  - funct3 100 (LBU): the same byte, zero-extended.
  - funct3 001 (LH): if off[1]=0, bits 15:0; else bits 31:16. off[0] is ignored. Sign-extended.
  - funct3 101 (LHU): the same halfword, zero-extended.
  - funct3 010 (LW): the full word; off is ignored.
  - Any other funct3: the raw word, unmodified.
- Select: W_wb_data = W_wb_sel ? aligned load : W_alu_out. The output follows its inputs regardless of W_valid.
- Write: on a rising clk, reg[W_rd] <= W_wb_data iff W_valid & W_wb_en & (W_rd != 0).
  - Writes to x0 are dropped; x0 always reads 0.
  - Single write port, so there is one write per cycle.
- Read: D_rsN_data = (index == 0) ? 0 : reg[index]. The read is asynchronous.
  - Same-cycle read/write of the same index follows WB_BYPASS_EN (see Optional Feature).
  - Both ports may read the same index simultaneously.
- Counter: instret increments by 1 on each rising clk with W_valid=1, independent of W_wb_en. It wraps from 2^CNT_W-1 to 0 with no flag.
- Latency: the write is visible on the read ports one cycle after commit, or in the same cycle with bypass enabled.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when a read index equals W_rd, is nonzero, and W_valid & W_wb_en are high, that read port returns W_wb_data in the same cycle (write-first). Decode needs no W-stage forwarding.
- Undefined: the read port returns the stored (old) value until the next edge. The hazard/forwarding unit must cover the W->D distance.

Test Plan:
- Reset then read: pulse rst, read x5 and x31 -> both 0, instret=0. Assert rst mid-write of x3 -> x3 stays 0.
- ALU write-back: W_valid=1, wb_en=1, wb_sel=0, rd=7, alu_out=0x1234_5678 -> after the edge, rs1=7 reads 0x12345678 and instret=1. The same with rd=0 -> x0 still reads 0.
- Load extension: ld_data=0x80FF_7F81, wb_sel=1, all with rd=9:
  - LB off=0 -> 0xFFFFFF81.
  - LBU off=3 -> 0x00000080.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=0 -> 0x00007F81.
  - LW -> 0x80FF7F81.
- Bubble/no-write: W_valid=0 with wb_en=1, rd=4 -> x4 unchanged and instret unchanged. W_valid=1 with wb_en=0 -> x4 unchanged and instret+1.
- Same-cycle hazard: write 0xDEAD_BEEF to x10 while rs2 index=10, old value 0x11:
  - WB_BYPASS_EN defined -> rs2 reads 0xDEADBEEF in the same cycle.
  - Undefined -> rs2 reads 0x11, then 0xDEADBEEF after the edge.
- Counter wrap: CNT_W=4, 17 valid cycles -> instret reads 1.
